// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, reset PC
// and the prefetch queue entry layout.
package if_pkg;

  localparam int IF_PC_W     = 8;
  localparam int IF_INSTR_W  = 20;
  localparam int IF_RESET_PC = 0;

  typedef struct packed {
    logic [IF_PC_W-1:0]    pc;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_q.sv
// DEPTH-entry synchronous FIFO holding fetched {pc, instr} pairs; flush beats
// push/pop, and push+pop together is legal when full.
module if_prefetch_q
  import if_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  entry_t          hold;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Once drained, keep showing the most recent head rather than a stale slot.
  assign dout  = empty ? hold : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (!empty) hold <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC generation, combinational imem read, prefetch queue and
// valid/ready hand-off to ID, with branch redirect flushing the queue.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int PC_W     = IF_PC_W,
  parameter int INSTR_W  = IF_INSTR_W,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = IF_RESET_PC,
  parameter int PC_INC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    fetch_pc
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam int CW = $clog2(DEPTH + 1);

  entry_t          q_din;
  entry_t          q_dout;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic            push;
  logic            pop;
  logic            unused_count;

  assign unused_count = ^q_count;

  // Redirect masks valid in its own cycle so ID never takes a wrong-path word.
  assign out_valid = !q_empty && !redirect;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect && (!q_full || pop);

  assign imem_addr   = fetch_pc;
  assign q_din.pc    = fetch_pc;
  assign q_din.instr = imem_rdata;
  assign out_pc      = q_dout.pc;
  assign out_instr   = q_dout.instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fetch_pc <= PC_W'(RESET_PC);
    else if (redirect) fetch_pc <= redirect_pc;
    else if (push)     fetch_pc <= fetch_pc + PC_W'(PC_INC);
  end

  if_prefetch_q #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scenario bench for if_fetch_unit: expected PCs are queued when stimulus is
// driven and popped whenever ID accepts an instruction.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [19:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_pc;
  logic [19:0] out_instr;
  logic [7:0]  fetch_pc;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  e;

  always #5 clk = ~clk;

  // Instruction memory image: word at address a is a + 0x100.
  assign imem_rdata = {12'h000, imem_addr} + 20'h100;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .fetch_pc    (fetch_pc)
  );

  function automatic logic [19:0] exp_instr(input logic [7:0] pc);
    return {12'h000, pc} + 20'h100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (fetch_pc !== 8'h00) begin errors++; $display("FAIL rst_fetch_pc got %h exp 00", fetch_pc); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_imem_addr got %h exp 00", imem_addr); end
    checks++; if (out_pc !== 8'h00 || out_instr !== 20'h0) begin errors++; $display("FAIL rst_head got %h/%h exp 00/00000", out_pc, out_instr); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_empty got %b exp 0", out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 20'h00100) begin
      errors++; $display("FAIL first_valid got %b %h %h exp 1 00 00100", out_valid, out_pc, out_instr); end
    checks++; if (fetch_pc !== 8'h01) begin errors++; $display("FAIL first_fetch_pc got %h exp 01", fetch_pc); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    for (int c = 0; c < 10; c++) begin
      out_ready = 1'b1; #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d got %b exp 1", c, out_valid); end
      if (out_valid && out_ready) begin
        checks++; e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (out_pc !== e || out_instr !== exp_instr(e) || fetch_pc !== e + 8'd1) begin
          errors++; $display("FAIL stream_seq got %h/%h fetch %h exp %h/%h fetch %h", out_pc, out_instr, fetch_pc, e, exp_instr(e), e + 8'd1); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(i));
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 3 && c <= 7); #1;
      if (c >= 4 && c <= 7) begin
        checks++; if (fetch_pc !== 8'h04 || out_valid !== 1'b1 || out_pc !== 8'h02) begin
          errors++; $display("FAIL stall_hold c%0d got fetch %h valid %b pc %h exp 04 1 02", c, fetch_pc, out_valid, out_pc); end
      end
      if (out_valid && out_ready) begin
        checks++; e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (out_pc !== e || out_instr !== exp_instr(e)) begin
          errors++; $display("FAIL stall_seq got %h/%h exp %h/%h", out_pc, out_instr, e, exp_instr(e)); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick();
    checks++; if (fetch_pc !== 8'h02 || out_valid !== 1'b1) begin
      errors++; $display("FAIL redir_pre got fetch %h valid %b exp 02 1", fetch_pc, out_valid); end
    redirect = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_mask got %b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h40 + 8'(i));
    tick();
    redirect = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || fetch_pc !== 8'h40) begin
      errors++; $display("FAIL redir_flush got valid %b fetch %h exp 0 40", out_valid, fetch_pc); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== 20'h00140) begin
      errors++; $display("FAIL redir_target got %b %h %h exp 1 40 00140", out_valid, out_pc, out_instr); end
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        checks++; e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (out_pc !== e || out_instr !== exp_instr(e)) begin
          errors++; $display("FAIL redir_seq got %h/%h exp %h/%h", out_pc, out_instr, e, exp_instr(e)); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 8'h80; out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstall_mask got %b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 + 8'(i));
    tick();
    redirect = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || fetch_pc !== 8'h80) begin
      errors++; $display("FAIL rstall_flush got valid %b fetch %h exp 0 80", out_valid, fetch_pc); end
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h80 || fetch_pc !== 8'h82) begin
      errors++; $display("FAIL rstall_head got %b %h fetch %h exp 1 80 82", out_valid, out_pc, fetch_pc); end
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b1; #1;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        checks++; e = exp_q.pop_front();
        if (out_pc !== e || out_instr !== exp_instr(e)) begin
          errors++; $display("FAIL rstall_seq got %h/%h exp %h/%h", out_pc, out_instr, e, exp_instr(e)); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstall_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 8'hFE; out_ready = 1'b1; #1;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    tick();
    redirect = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        checks++; e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (out_pc !== e || out_instr !== exp_instr(e) || fetch_pc !== e + 8'd1) begin
          errors++; $display("FAIL wrap_seq got %h/%h fetch %h exp %h/%h fetch %h", out_pc, out_instr, fetch_pc, e, exp_instr(e), e + 8'd1); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_pc = 8'h10; out_ready = 1'b1;
    tick();
    redirect_pc = 8'h20; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_mask got %b exp 0", out_valid); end
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h20 + 8'(i));
    tick();
    redirect = 1'b0; #1;
    checks++; if (fetch_pc !== 8'h20 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_fetch got %h valid %b exp 20 0", fetch_pc, out_valid); end
    tick();
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        checks++; e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (out_pc !== e || out_instr !== exp_instr(e)) begin
          errors++; $display("FAIL b2b_seq got %h/%h exp %h/%h", out_pc, out_instr, e, exp_instr(e)); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_async_reset();
    redirect = 1'b1; redirect_pc = 8'h30; out_ready = 1'b0;
    tick();
    redirect = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 8'h30 || fetch_pc !== 8'h32) begin
      errors++; $display("FAIL areset_pre got %b %h fetch %h exp 1 30 32", out_valid, out_pc, fetch_pc); end
    #3;
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || fetch_pc !== 8'h00) begin
      errors++; $display("FAIL areset_now got valid %b fetch %h exp 0 00", out_valid, fetch_pc); end
    checks++; if (out_pc !== 8'h00 || out_instr !== 20'h0) begin
      errors++; $display("FAIL areset_head got %h/%h exp 00/00000", out_pc, out_instr); end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        checks++; e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        if (out_pc !== e || out_instr !== exp_instr(e)) begin
          errors++; $display("FAIL areset_seq got %h/%h exp %h/%h", out_pc, out_instr, e, exp_instr(e)); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL areset_drain left %0d exp 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised successor to the single-cycle IF stage.
- Generates the fetch PC and reads an external combinational instruction memory.
- Buffers fetched instructions in a small prefetch queue.
- Presents them to ID with a valid/ready handshake.
- Accepts a branch/jump redirect that flushes the queue and restarts fetch at a target PC.
- Sits between the PC/instruction memory and the IF/ID pipeline register; the ready input is driven by the hazard unit's inverted stall.

Parameters:
- PC_W, 8, fetch PC width in bits; PC wraps modulo 2^PC_W.
- INSTR_W, 20, instruction word width.
- DEPTH, 2, prefetch queue entries; must be a power of 2 and >= 2.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 1, PC increment per fetch (word-addressed memory uses 1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- imem_addr, output, PC_W, address to instruction memory (equals fetch_pc).
- imem_rdata, input, INSTR_W, combinational read data for imem_addr, valid in the same cycle.
- redirect, input, 1, taken branch/jump from EX; flush and restart.
- redirect_pc, input, PC_W, target PC, sampled when redirect=1.
- out_ready, input, 1, ID accepts this cycle (hazard unit drives !stall).
- out_valid, output, 1, head entry is valid.
- out_pc, output, PC_W, PC of the head instruction.
- out_instr, output, INSTR_W, head instruction word.
- fetch_pc, output, PC_W, next PC to be fetched (debug/trace).

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- While rst=1:
  - fetch_pc = RESET_PC.
  - Queue count = 0; read and write pointers = 0.
  - out_valid = 0.
  - out_pc and out_instr = 0.
- Reset mid-operation discards all queued entries immediately; no partial state survives.
- Queue contents: each entry holds {pc, instr}. Output fields are driven combinationally from the head entry: out_pc and out_instr come from the head; when empty they hold the last head value.
- pop = out_valid && out_ready.
- out_valid = (count != 0) && !redirect. Redirect masks valid combinationally, so ID never accepts a wrong-path instruction in the redirect cycle.
- push = !redirect && (count < DEPTH || pop).
  - Full with a simultaneous pop still pushes, so DEPTH=2 sustains 1 instruction/cycle.
- On push: enqueue {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc + PC_INC, truncated to PC_W bits (e.g. 0xFF+1 -> 0x00 at PC_W=8).
- On no push and no redirect: fetch_pc holds.
- Count update: count += push - pop.
- Redirect (highest priority after reset), next edge:
  - count <= 0; pointers <= 0.
  - fetch_pc <= redirect_pc.
  - No push or pop occurs that cycle.
  - First instruction from the target appears at out_valid one cycle later: redirect at edge N, target visible and valid after edge N+1.
- Latency:
  - Reset release to first out_valid = 1 cycle (fetch at edge 1, valid after it).
  - Fetch-to-output latency = 1 cycle when the queue is empty.
- Stall: out_ready=0 with queue full means no push and fetch_pc holds. Entries are preserved in order; no instruction is lost or duplicated.
- Back-to-back redirects: each one restarts from its own target; the last one wins.
- Invariants:
  - 0 <= count <= DEPTH.
  - Queued PCs are consecutive modulo 2^PC_W by PC_INC, in order.

Decomposition:
- Shared package if_pkg:
  - PC_W and INSTR_W defaults.
  - RESET_PC.
  - typedef fetch_entry_t {pc, instr}.
- One natural sub-module: if_prefetch_q, a DEPTH-entry synchronous FIFO.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Supports simultaneous push+pop when full.
  - flush has priority over push/pop.
- Top-level if_fetch_unit holds the PC register, push/pop control and redirect muxing.

Test Plan:
- Reset, then out_ready=1 constant, imem_rdata = addr+0x100: out_valid=1 from cycle 1; out_pc sequence 0,1,2,3… with out_instr 0x100,0x101,…, one per cycle.
- Hold out_ready=0 for 5 cycles after cycle 2: count saturates at 2; fetch_pc holds at 4; on release, out_pc continues 2,3,4 in order with no gaps or duplicates.
- Redirect with redirect_pc=0x40 while 2 entries are queued: out_valid=0 that cycle; next cycle count=0 and fetch_pc=0x40; the following cycle out_pc=0x40 and out_valid=1.
- Redirect asserted together with out_ready=0 and a full queue: flush wins; fetch_pc=target; no stale PC is ever presented.
- Redirect to 0xFE, then free-run: out_pc sequence 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Assert rst mid-stream with 2 entries queued: out_valid=0 and fetch_pc=RESET_PC immediately (asynchronous); after release, the sequence restarts at RESET_PC.
